updown_count_ctrl: RTL
======================

Name:
updown_count_ctrl

Overview:
- Command-driven sequencer for an N-bit saturating up/down counter.
- Accepts a target value over a valid/ready handshake and computes the direction.
- Steps the counter one LSB every PRESCALE cycles until count equals target, then pulses done.
- Lets a lab top-level, or a higher-level FSM, drive the counter to a set value instead of hand-toggling up_down.

Parameters:
- N, 4, counter and target width in bits (N >= 1).
- PRESCALE, 1, clock cycles per count step (PRESCALE >= 1). The prescale counter is max(1, clog2(PRESCALE)) bits wide.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  controller can accept a command; high only in IDLE.
- cmd_target  input  N  target count value.
- cmd_clear  input  1  with an accepted command: zero the count, ignore cmd_target.
- abort  input  1  stop the current run, keep the current count.
- cnt  output  N  current count (registered).
- dir  output  1  direction of the last/current run: 1 = up, 0 = down.
- busy  output  1  high in RUN.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Reset (rst_n = 0, asynchronous; takes effect immediately, including mid-run):
  - state = IDLE, cnt = 0, dir = 1, busy = 0, done = 0, prescale counter = 0.
  - No done pulse is generated by reset.
- State machine has three states: IDLE, RUN, DONE.
  - cmd_ready = (state == IDLE).
  - busy = (state == RUN).
  - done = (state == DONE).
- IDLE, on an edge where cmd_valid && cmd_ready:
  - If cmd_clear: cnt <= 0 at that edge, next state DONE. cmd_target is ignored.
  - Else if cmd_target == cnt: next state DONE; cnt and dir unchanged.
  - Else: dir <= (cmd_target > cnt) as an unsigned compare; target latched; prescale counter <= 0; next state RUN.
- IDLE, otherwise: hold. abort is ignored in IDLE.
- RUN:
  - The prescale counter increments every cycle.
  - When it reaches PRESCALE-1: cnt steps one toward target (+1 if dir, else -1) and the prescale counter returns to 0.
  - On the edge where the stepped cnt equals target: next state DONE.
  - Timing: run accepted at edge k; first step at edge k+PRESCALE; final step at edge k + D*PRESCALE, where D = |target - cnt_at_accept|.
  - done is high in the cycle after the final step edge. cmd_ready returns high one cycle after that.
- abort in RUN: next state IDLE at that edge. cnt keeps its value, including any step that coincides with the same edge. No done pulse.
- abort on the same edge as the final step: abort wins; state goes IDLE with cnt == target and no done pulse.
- DONE: lasts exactly one cycle, then IDLE. abort and cmd_valid are ignored.
- Arithmetic:
  - All compares are unsigned.
  - cnt never wraps. Because the target is within [0, 2^N-1], stepping stops at the target. The step logic still saturates at 0 and at all-ones as a safety bound.
- Latched target: commands are accepted only in IDLE. A change on cmd_target during RUN has no effect.

Decomposition:
- Shared package holds:
  - state encoding constants IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;
  - direction constants DIR_UP = 1'b1, DIR_DN = 1'b0.
- Sub-module sat_updown_step:
  - N-bit registered counter with ports clk, rst_n, en, clr, up_down, cnt;
  - saturates at 0 and 2^N-1;
  - clr has priority over en.
- The controller instantiates sat_updown_step and owns the FSM, the prescaler and the latched target.

Test Plan:
All scenarios use N = 4, PRESCALE = 2 unless stated.
1. Reset then count up: release rst_n, command target = 5 from cnt = 0.
   - cnt = 1, 2, 3, 4, 5 on every 2nd edge; dir = 1.
   - busy is high for 10 cycles, then done is high for 1 cycle.
   - cmd_ready is high again the next cycle.
2. Count down: from cnt = 5, command target = 2.
   - dir = 0; cnt = 4, 3, 2; done pulses once.
   - From cnt = 15, target = 0: 15 steps, and cnt never wraps below 0.
3. Equal target and clear:
   - From cnt = 7, target = 7: no RUN state, done pulses on the next cycle, cnt stays 7.
   - From cnt = 9, cmd_clear = 1: cnt = 0 after one edge, then done pulses.
4. Abort mid-run: target = 12 from 0, assert abort when cnt = 3.
   - State goes IDLE, cnt holds 3, no done pulse, cmd_ready = 1.
   - A new target = 1 then counts down (dir = 0).
5. Handshake and async reset:
   - cmd_valid held high with a changing cmd_target during RUN: only the first command is accepted, and the latched target is used.
   - Drop rst_n asynchronously (mid-cycle) at cnt = 6: cnt = 0, busy = 0 and done = 0 immediately, with no clock edge needed.
6. PRESCALE = 1 variant: target = 3 from 0.
   - cnt steps on every edge (1, 2, 3).
   - done is high in the cycle after cnt reaches 3.

Source files
------------

// File: rtl/updown_count_ctrl_pkg.sv
// Shared definitions for the up/down count controller: FSM states,
// direction codes and the prescaler width rule.
package updown_count_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  // Prescale counter width: max(1, clog2(PRESCALE)).
  function automatic int pre_width(input int prescale);
    return (prescale <= 2) ? 1 : $clog2(prescale);
  endfunction

endpackage

// File: rtl/updown_count_ctrl_sat_updown_step.sv
// N-bit registered up/down counter that saturates at 0 and all-ones;
// clear has priority over enable.
module sat_updown_step
  import updown_count_ctrl_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_en,
  input  logic         i_clr,
  input  logic         i_up_down,
  output logic [N-1:0] o_cnt
);

  logic [N-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      if (i_up_down == DIR_UP) begin
        if (r_cnt != '1) r_cnt <= r_cnt + 1'b1;
      end else begin
        if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/updown_count_ctrl.sv
// Command-driven sequencer: walks a saturating counter one LSB every
// PRESCALE cycles toward a latched target, then pulses done.
//   state | meaning
//   IDLE  | waiting for a command, cmd_ready high
//   RUN   | stepping toward the latched target
//   DONE  | one-cycle completion pulse
module updown_count_ctrl
  import updown_count_ctrl_pkg::*;
#(
  parameter int N        = 4,
  parameter int PRESCALE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_cmd_valid,
  output logic         o_cmd_ready,
  input  logic [N-1:0] i_cmd_target,
  input  logic         i_cmd_clear,
  input  logic         i_abort,
  output logic [N-1:0] o_cnt,
  output logic         o_dir,
  output logic         o_busy,
  output logic         o_done
);

  localparam int            PW      = pre_width(PRESCALE);
  localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);
  localparam logic [PW-1:0] PRE_ONE = PW'(1);
  localparam logic [N:0]    EXT_ONE = (N+1)'(1);

  state_t        r_state;
  logic          r_dir;
  logic [N-1:0]  r_target;
  logic [PW-1:0] r_pre;

  logic [N-1:0]  w_cnt;
  logic          w_accept;
  logic          w_step;
  logic          w_last;
  logic [N:0]    w_cnt_x;
  logic [N:0]    w_tgt_x;

  assign w_accept = (r_state == IDLE) && i_cmd_valid;
  assign w_step   = (r_state == RUN) && (r_pre == PRE_MAX);
  assign w_cnt_x  = {1'b0, w_cnt};
  assign w_tgt_x  = {1'b0, r_target};
  // One extra bit so the "next step lands on target" test cannot wrap.
  assign w_last   = (r_dir == DIR_UP) ? (w_cnt_x + EXT_ONE == w_tgt_x)
                                      : (w_tgt_x + EXT_ONE == w_cnt_x);

  sat_updown_step #(.N(N)) u_step (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_en      (w_step),
    .i_clr     (w_accept && i_cmd_clear),
    .i_up_down (r_dir),
    .o_cnt     (w_cnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_dir    <= DIR_UP;
      r_target <= '0;
      r_pre    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_cmd_valid) begin
            if (i_cmd_clear || (i_cmd_target == w_cnt)) begin
              r_state <= DONE;
            end else begin
              r_dir    <= (i_cmd_target > w_cnt) ? DIR_UP : DIR_DN;
              r_target <= i_cmd_target;
              r_pre    <= '0;
              r_state  <= RUN;
            end
          end
        end
        RUN: begin
          r_pre <= w_step ? '0 : r_pre + PRE_ONE;
          // Abort wins over a coinciding final step; the step itself still lands.
          if (i_abort)              r_state <= IDLE;
          else if (w_step && w_last) r_state <= DONE;
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_cmd_ready = (r_state == IDLE);
  assign o_busy      = (r_state == RUN);
  assign o_done      = (r_state == DONE);
  assign o_dir       = r_dir;
  assign o_cnt       = w_cnt;

endmodule
